// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, tag constants and bundle types for the
// common-data-bus path between the functional units and the ROB.
package cpu_pkg;

  localparam int ROB_W  = 6;
  localparam int DATA_W = 32;

  typedef logic [ROB_W-1:0] rob_tag_t;

  localparam rob_tag_t INVALID_ROB = 6'd16;

  typedef struct packed {
    logic              valid;
    rob_tag_t          rob;
    logic [DATA_W-1:0] data;
  } cdb_pkt_t;

  function automatic int wrap_add(
    input int base,
    input int off,
    input int n
  );
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo: shallow per-producer result queue feeding the CDB arbiter.
// Pointers wrap naturally because DEPTH is a power of two.
module cdb_fifo #(
  parameter int DEPTH  = 2,
  parameter int ROB_W  = 6,
  parameter int DATA_W = 32,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [ROB_W-1:0]  push_rob,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ROB_W-1:0]  head_rob,
  output logic [DATA_W-1:0] head_data,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full
);

  logic [ROB_W-1:0]  rob_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic              do_push;
  logic              do_pop;

  assign full    = cnt == CW'(DEPTH);
  assign empty   = cnt == '0;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign count     = cnt;
  assign head_rob  = rob_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage needs no reset: count gates every read.
  always_ff @(posedge clock) begin
    if (do_push) begin
      rob_mem[wr_ptr]  <= push_rob;
      data_mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin pick of up to two queued results per cycle,
// broadcast as registered packets on CDB ports 0 and 1.
module cdb_arbiter
  import cpu_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DEPTH   = 2,
  parameter int ROB_W   = cpu_pkg::ROB_W,
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter logic [ROB_W-1:0] INVALID_ROB = cpu_pkg::INVALID_ROB
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*ROB_W-1:0]  src_rob,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      CDBiscast,
  output logic [ROB_W-1:0]          CDBrobNum,
  output logic [DATA_W-1:0]         CDBdata,
  output logic                      CDBiscast2,
  output logic [ROB_W-1:0]          CDBrobNum2,
  output logic [DATA_W-1:0]         CDBdata2
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [CW-1:0]      count     [NUM_SRC];
  logic [ROB_W-1:0]   head_rob  [NUM_SRC];
  logic [DATA_W-1:0]  head_data [NUM_SRC];

  logic [IW-1:0]      rr;
  logic [IW-1:0]      rr_nxt;
  logic [NUM_SRC-1:0] rot;
  logic [IW-1:0]      p0;
  logic [IW-1:0]      p1;
  logic               p0_v;
  logic               p1_v;
  logic [IW-1:0]      g0;
  logic [IW-1:0]      g1;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_q
    assign src_ready[i] = !reset &&
      (count[i] < CW'(DEPTH));
    assign push[i] = src_valid[i] && !full[i];

    cdb_fifo #(
      .DEPTH (DEPTH),
      .ROB_W (ROB_W),
      .DATA_W(DATA_W)
    ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .flush    (flush),
      .push     (push[i]),
      .push_rob (src_rob[i*ROB_W +: ROB_W]),
      .push_data(src_data[i*DATA_W +: DATA_W]),
      .pop      (pop[i]),
      .head_rob (head_rob[i]),
      .head_data(head_data[i]),
      .count    (count[i]),
      .empty    (empty[i]),
      .full     (full[i])
    );
  end

  // Rotate occupancy so that slot 0 is the current rr source.
  always_comb begin
    rot = '0;
    for (int j = 0; j < NUM_SRC; j++)
      rot[j] = !empty[IW'(wrap_add(int'(rr), j, NUM_SRC))];
  end

  always_comb begin
    p0_v = 1'b0;
    p1_v = 1'b0;
    p0   = '0;
    p1   = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (rot[j]) begin
        if (!p0_v) begin
          p0_v = 1'b1;
          p0   = IW'(j);
        end else if (!p1_v) begin
          p1_v = 1'b1;
          p1   = IW'(j);
        end
      end
    end
  end

  assign g0 = IW'(wrap_add(int'(p0), int'(rr), NUM_SRC));
  assign g1 = IW'(wrap_add(int'(p1), int'(rr), NUM_SRC));

  always_comb begin
    rr_nxt = rr;
    if (p1_v)
      rr_nxt = IW'(wrap_add(int'(g1), 1, NUM_SRC));
    else if (p0_v)
      rr_nxt = IW'(wrap_add(int'(g0), 1, NUM_SRC));
  end

  always_comb begin
    pop = '0;
    if (p0_v)
      pop[g0] = 1'b1;
    if (p1_v)
      pop[g1] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr         <= '0;
      CDBiscast  <= 1'b0;
      CDBrobNum  <= INVALID_ROB;
      CDBdata    <= '0;
      CDBiscast2 <= 1'b0;
      CDBrobNum2 <= INVALID_ROB;
      CDBdata2   <= '0;
    end else if (flush) begin
      rr         <= '0;
      CDBiscast  <= 1'b0;
      CDBrobNum  <= INVALID_ROB;
      CDBdata    <= '0;
      CDBiscast2 <= 1'b0;
      CDBrobNum2 <= INVALID_ROB;
      CDBdata2   <= '0;
    end else begin
      rr         <= rr_nxt;
      CDBiscast  <= p0_v;
      CDBrobNum  <= p0_v ? head_rob[g0] : INVALID_ROB;
      CDBdata    <= p0_v ? head_data[g0] : '0;
      CDBiscast2 <= p1_v;
      CDBrobNum2 <= p1_v ? head_rob[g1] : INVALID_ROB;
      CDBdata2   <= p1_v ? head_data[g1] : '0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table vectors, saturation scoreboard, random traffic
// against a queue-level model, and asynchronous reset corner cases.
module tb_cdb_arbiter;
  import cpu_pkg::*;

  localparam int N = 4;
  localparam int D = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush;
  logic [N-1:0] src_valid;
  logic [N-1:0] src_ready;
  logic [N*ROB_W-1:0] src_rob;
  logic [N*DATA_W-1:0] src_data;
  logic CDBiscast, CDBiscast2;
  logic [ROB_W-1:0] CDBrobNum, CDBrobNum2;
  logic [DATA_W-1:0] CDBdata, CDBdata2;

  cdb_arbiter #(
    .NUM_SRC(N), .DEPTH(D), .ROB_W(ROB_W),
    .DATA_W(DATA_W), .INVALID_ROB(INVALID_ROB)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .src_valid(src_valid), .src_rob(src_rob),
    .src_data(src_data), .src_ready(src_ready),
    .CDBiscast(CDBiscast), .CDBrobNum(CDBrobNum),
    .CDBdata(CDBdata), .CDBiscast2(CDBiscast2),
    .CDBrobNum2(CDBrobNum2), .CDBdata2(CDBdata2)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one FIFO per source, rr as a plain integer.
  cdb_pkt_t mq[N][$];
  int mrr;
  cdb_pkt_t e0, e1;

  function automatic cdb_pkt_t idle_pkt();
    cdb_pkt_t p;
    p.valid = 1'b0;
    p.rob = INVALID_ROB;
    p.data = '0;
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    mrr = 0;
    e0 = idle_pkt();
    e1 = idle_pkt();
  endtask

  task automatic model_edge(output logic [N-1:0] acc);
    int pick[$];
    cdb_pkt_t p;
    for (int i = 0; i < N; i++)
      acc[i] = src_valid[i] && (mq[i].size() < D) && !flush;
    e0 = idle_pkt();
    e1 = idle_pkt();
    if (flush) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      mrr = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        int s;
        s = (mrr + k) % N;
        if (mq[s].size() != 0 && pick.size() < 2) pick.push_back(s);
      end
      if (pick.size() > 0) begin
        e0 = mq[pick[0]].pop_front();
        mrr = (pick[pick.size()-1] + 1) % N;
      end
      if (pick.size() > 1) e1 = mq[pick[1]].pop_front();
      for (int i = 0; i < N; i++)
        if (acc[i]) begin
          p.valid = 1'b1;
          p.rob = src_rob[i*ROB_W +: ROB_W];
          p.data = src_data[i*DATA_W +: DATA_W];
          mq[i].push_back(p);
        end
    end
  endtask

  task automatic step(output logic [N-1:0] acc);
    model_edge(acc);
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string nm);
    chk({nm, ".cast0"}, CDBiscast, e0.valid);
    chk({nm, ".rob0"}, CDBrobNum, e0.rob);
    chk({nm, ".data0"}, CDBdata, e0.data);
    chk({nm, ".cast1"}, CDBiscast2, e1.valid);
    chk({nm, ".rob1"}, CDBrobNum2, e1.rob);
    chk({nm, ".data1"}, CDBdata2, e1.data);
  endtask

  task automatic chk_ready_model(input string nm);
    logic [N-1:0] exp;
    for (int i = 0; i < N; i++) exp[i] = mq[i].size() < D;
    chk(nm, src_ready, exp);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".cast0"}, CDBiscast, 0);
    chk({nm, ".rob0"}, CDBrobNum, INVALID_ROB);
    chk({nm, ".data0"}, CDBdata, 0);
    chk({nm, ".cast1"}, CDBiscast2, 0);
    chk({nm, ".rob1"}, CDBrobNum2, INVALID_ROB);
    chk({nm, ".data1"}, CDBdata2, 0);
    chk({nm, ".ready"}, src_ready, 0);
  endtask

  // Producer side: each source holds its result until accepted.
  logic [N-1:0] pv;
  rob_tag_t pr[N];
  logic [DATA_W-1:0] pd[N];
  int next_tag = 0;

  task automatic alloc(output rob_tag_t t);
    t = rob_tag_t'(next_tag);
    next_tag = (next_tag + 1) % 64;
    if (next_tag == int'(INVALID_ROB)) next_tag++;
  endtask

  task automatic drive_pend();
    src_valid = pv;
    for (int i = 0; i < N; i++) begin
      src_rob[i*ROB_W +: ROB_W] = pr[i];
      src_data[i*DATA_W +: DATA_W] = pd[i];
    end
  endtask

  always @(negedge clock) begin
    if (chk_on && !reset) begin
      chk("cast2_without_cast", CDBiscast2 && !CDBiscast, 0);
      if (CDBiscast && CDBiscast2)
        chk("dup_port_tag", CDBrobNum == CDBrobNum2, 0);
      for (int i = 0; i < N; i++)
        if (src_valid[i] && src_ready[i])
          chk("push_invalid_tag",
              src_rob[i*ROB_W +: ROB_W] == INVALID_ROB, 0);
    end
  end

  typedef struct {
    logic fl;
    logic [N-1:0] v;
    rob_tag_t r[N];
    logic c0;
    rob_tag_t e0;
    logic c1;
    rob_tag_t e1;
    logic [N-1:0] rdy;
  } vec_t;
  vec_t tv[$];

  function automatic logic [DATA_W-1:0] dat(input rob_tag_t r);
    return (r == 6'd3) ? 32'h1234 : 32'hD000 + 32'(r);
  endfunction

  task automatic add(input logic fl, input logic [N-1:0] v,
                     input int r0, input int r1, input int r2,
                     input int r3, input logic c0, input int x0,
                     input logic c1, input int x1,
                     input logic [N-1:0] rdy);
    vec_t t;
    t.fl = fl; t.v = v;
    t.r[0] = rob_tag_t'(r0); t.r[1] = rob_tag_t'(r1);
    t.r[2] = rob_tag_t'(r2); t.r[3] = rob_tag_t'(r3);
    t.c0 = c0; t.e0 = rob_tag_t'(x0);
    t.c1 = c1; t.e1 = rob_tag_t'(x1);
    t.rdy = rdy;
    tv.push_back(t);
  endtask

  rob_tag_t sb[N][$];
  int owner[64];
  int gcnt[N];
  bit saw_full;

  task automatic consume_one(input logic v, input rob_tag_t r,
                             input bit cnt);
    int s;
    if (!v) return;
    s = owner[r];
    if (s < 0 || sb[s].size() == 0) begin
      chk("sat.unexpected_tag", r, INVALID_ROB);
    end else begin
      chk("sat.order", r, sb[s].pop_front());
      if (cnt) gcnt[s]++;
    end
  endtask

  task automatic saturate(input int cycles, input bit score);
    logic [N-1:0] acc;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++)
        if (!pv[i]) begin
          alloc(pr[i]);
          pd[i] = $urandom;
          pv[i] = 1'b1;
        end
      flush = 1'b0;
      drive_pend();
      chk_ready_model("sat.ready");
      if (src_ready != '1) saw_full = 1;
      step(acc);
      for (int i = 0; i < N; i++)
        if (acc[i]) begin
          if (score) begin
            sb[i].push_back(pr[i]);
            owner[pr[i]] = i;
          end
          pv[i] = 1'b0;
        end
      chk_out("sat");
      if (score) begin
        consume_one(CDBiscast, CDBrobNum, 1);
        consume_one(CDBiscast2, CDBrobNum2, 1);
      end
    end
  endtask

  initial begin
    logic [N-1:0] acc;
    int mx, mn;
    flush = 0; src_valid = '0; src_rob = '0; src_data = '0;
    pv = '0;
    for (int i = 0; i < N; i++) begin pr[i] = '0; pd[i] = '0; end
    for (int i = 0; i < 64; i++) owner[i] = -1;
    model_reset();

    // Reset raised between edges must clear outputs without a clock.
    #1 reset = 1'b1;
    #2 chk_reset_vals("reset_async");
    @(posedge clock); #1;
    reset = 1'b0;
    step(acc);
    chk("post_reset.ready", src_ready, 4'b1111);
    chk_out("post_reset");
    chk_on = 1;

    add(0, 4'b0100, 0, 0, 3, 0,  0, 16, 0, 16, 4'b1111);
    add(0, 4'b0000, 0, 0, 0, 0,  1, 3,  0, 16, 4'b1111);
    add(0, 4'b0000, 0, 0, 0, 0,  0, 16, 0, 16, 4'b1111);
    add(1, 4'b0000, 0, 0, 0, 0,  0, 16, 0, 16, 4'b1111);
    add(0, 4'b1111, 1, 2, 3, 4,  0, 16, 0, 16, 4'b1111);
    add(0, 4'b0000, 0, 0, 0, 0,  1, 1,  1, 2,  4'b1111);
    add(0, 4'b0000, 0, 0, 0, 0,  1, 3,  1, 4,  4'b1111);
    add(0, 4'b0000, 0, 0, 0, 0,  0, 16, 0, 16, 4'b1111);
    add(0, 4'b1111, 10, 11, 20, 21, 0, 16, 0, 16, 4'b1111);
    add(0, 4'b0011, 12, 13, 0, 0, 1, 10, 1, 11, 4'b1111);
    add(0, 4'b0001, 14, 0, 0, 0, 1, 20, 1, 21, 4'b1110);
    add(1, 4'b0010, 0, 30, 0, 0, 0, 16, 0, 16, 4'b1111);
    add(0, 4'b0010, 0, 5, 0, 0,  0, 16, 0, 16, 4'b1111);
    add(0, 4'b0000, 0, 0, 0, 0,  1, 5,  0, 16, 4'b1111);
    add(0, 4'b0000, 0, 0, 0, 0,  0, 16, 0, 16, 4'b1111);

    foreach (tv[n]) begin
      flush = tv[n].fl;
      src_valid = tv[n].v;
      for (int i = 0; i < N; i++) begin
        src_rob[i*ROB_W +: ROB_W] = tv[n].r[i];
        src_data[i*DATA_W +: DATA_W] = dat(tv[n].r[i]);
      end
      step(acc);
      chk($sformatf("tv%0d.cast0", n), CDBiscast, tv[n].c0);
      chk($sformatf("tv%0d.rob0", n), CDBrobNum, tv[n].e0);
      chk($sformatf("tv%0d.data0", n), CDBdata,
          tv[n].c0 ? dat(tv[n].e0) : 32'h0);
      chk($sformatf("tv%0d.cast1", n), CDBiscast2, tv[n].c1);
      chk($sformatf("tv%0d.rob1", n), CDBrobNum2, tv[n].e1);
      chk($sformatf("tv%0d.data1", n), CDBdata2,
          tv[n].c1 ? dat(tv[n].e1) : 32'h0);
      chk($sformatf("tv%0d.ready", n), src_ready, tv[n].rdy);
    end
    flush = 0; src_valid = '0;

    // Saturation: all sources push every cycle for 20 cycles.
    saw_full = 0;
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    saturate(20, 1);
    pv = '0;
    drive_pend();
    for (int c = 0; c < 6; c++) begin
      step(acc);
      chk_out("drain");
      consume_one(CDBiscast, CDBrobNum, 0);
      consume_one(CDBiscast2, CDBrobNum2, 0);
    end
    for (int i = 0; i < N; i++)
      chk($sformatf("sat.lost%0d", i), sb[i].size(), 0);
    chk("sat.ready_deasserted", saw_full, 1);
    mx = gcnt[0]; mn = gcnt[0];
    for (int i = 1; i < N; i++) begin
      if (gcnt[i] > mx) mx = gcnt[i];
      if (gcnt[i] < mn) mn = gcnt[i];
    end
    chk("sat.fairness", (mx - mn) <= 1, 1);
    chk("sat.grants_seen", mn > 0, 1);

    // Random traffic with occasional flushes.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++)
        if (!pv[i] && $urandom_range(0, 99) < 60) begin
          alloc(pr[i]);
          pd[i] = $urandom;
          pv[i] = 1'b1;
        end
      drive_pend();
      flush = ($urandom_range(0, 99) < 4);
      chk_ready_model("rnd.ready");
      step(acc);
      for (int i = 0; i < N; i++) if (acc[i]) pv[i] = 1'b0;
      chk_out("rnd");
    end
    flush = 0;

    // Asynchronous reset in the middle of a saturated stream.
    saturate(5, 0);
    #2 reset = 1'b1;
    #1 chk_reset_vals("reset_mid");
    pv = '0;
    drive_pend();
    model_reset();
    @(posedge clock); #1;
    chk_reset_vals("reset_hold");
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step(acc);
      chk_ready_model("after_reset.ready");
      chk_out("after_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
